// File: rtl/compare_sort_controller_if.sv
// rtl/compare_sort_controller_if.sv - stream and status bundle for compare_sort_controller
//
// Purpose: groups the upstream sample stream, the downstream sorted stream and
// the status outputs of compare_sort_controller into one interface.
// Signals:
//   inData       8  unsigned sample offered by the source
//   inValid      1  inData valid
//   inReady      1  controller accepts a sample (LOAD only)
//   outData      8  current sorted sample
//   outValid     1  outData valid (DRAIN only)
//   outReady     1  consumer accepts outData
//   busy         1  controller is sorting
//   compareCount 8  compares issued for the current block, saturating at 255
// Modports: master = source/consumer side, slave = controller side.

interface compare_sort_controller_if;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       busy;
  logic [7:0] compareCount;

  modport master (
    output inData, inValid, outReady,
    input  inReady, outData, outValid, busy, compareCount
  );

  modport slave (
    input  inData, inValid, outReady,
    output inReady, outData, outValid, busy, compareCount
  );
endinterface

// File: rtl/compare_sort_controller.sv
// rtl/compare_sort_controller.sv - in-place bubble sort of a DEPTH-sample block, one compare per clock
//
// Purpose: loads DEPTH unsigned 8-bit samples, bubble-sorts them in place using a
// single shared 8-bit comparator (one compare per clock), then drains them in order.
// Ports:
//   clock  in   single clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of compare_sort_controller_if (in/out streams, busy, compareCount)
// Parameters:
//   DEPTH  samples per block, 2..16
// Build option:
//   SORT_DESCENDING_EN  when defined, swap on P<Q so the block drains largest first;
//                       default swaps on P>Q (ascending). Ties never swap in either build.

module compare_sort_controller #(
  parameter int DEPTH = 8
) (
  input logic                      clock,
  input logic                      reset,
  compare_sort_controller_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  // Buffer rounded up to a power of two so idx+1 is always a legal address.
  localparam int BUF_N = 1 << IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] PASS_LAST = IDX_W'(DEPTH - 2);

  localparam logic [1:0] ST_LOAD  = 2'b00;
  localparam logic [1:0] ST_SORT  = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pass;
  logic             swapped;
  logic [7:0]       count;
  logic [7:0]       mem [BUF_N];

  logic [IDX_W-1:0] idx_pair;
  logic [7:0]       p;
  logic [7:0]       q;
  logic             swap_needed;
  logic             last_in_pass;
  logic             load_fire;
  logic             drain_fire;

  assign idx_pair = idx + IDX_W'(1);
  assign p        = mem[idx];
  assign q        = mem[idx_pair];

  // Shared comparator: strict inequality keeps equal samples in their original order.
`ifdef SORT_DESCENDING_EN
  assign swap_needed = (p < q);
`else
  assign swap_needed = (p > q);
`endif

  // Each pass shortens by one: the largest remaining element has bubbled to the end.
  assign last_in_pass = (idx == (PASS_LAST - pass));
  assign load_fire    = (state == ST_LOAD) && bus.inValid;
  assign drain_fire   = (state == ST_DRAIN) && bus.outReady;

  assign bus.inReady      = (state == ST_LOAD);
  assign bus.busy         = (state == ST_SORT);
  assign bus.outValid     = (state == ST_DRAIN);
  assign bus.outData      = (state == ST_DRAIN) ? mem[idx] : 8'd0;
  assign bus.compareCount = count;

  // Sample storage: no reset, contents are meaningless until a block is loaded.
  always_ff @(posedge clock) begin
    if (load_fire) begin
      mem[idx] <= bus.inData;
    end else if ((state == ST_SORT) && swap_needed) begin
      mem[idx]      <= q;
      mem[idx_pair] <= p;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_LOAD;
      idx     <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      count   <= 8'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            if (idx == IDX_LAST) begin
              state   <= ST_SORT;
              idx     <= '0;
              pass    <= '0;
              swapped <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        ST_SORT: begin
          if (count != 8'd255) begin
            count <= count + 8'd1;
          end
          if (swap_needed) begin
            swapped <= 1'b1;
          end
          if (last_in_pass) begin
            // The swap made by this final compare counts toward the pass, otherwise a
            // pass whose only swap is its last pair would end the sort too early.
            if (!(swapped || swap_needed) || (pass == PASS_LAST)) begin
              state <= ST_DRAIN;
              idx   <= '0;
            end else begin
              pass    <= pass + IDX_W'(1);
              idx     <= '0;
              swapped <= 1'b0;
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        ST_DRAIN: begin
          if (drain_fire) begin
            if (idx == IDX_LAST) begin
              state <= ST_LOAD;
              idx   <= '0;
              count <= 8'd0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        default: begin
          state   <= ST_LOAD;
          idx     <= '0;
          pass    <= '0;
          swapped <= 1'b0;
          count   <= 8'd0;
        end
      endcase
    end
  end

endmodule
